// File: rtl/sram_io_bridge.sv
// sram_io_bridge: turns LC-3 CPU memory strobes into a fixed-length, wait-stated
// access to an external async 16-bit SRAM, with address 0xFFFF mapped to
// switches (read) and the hex display register (write).
module sram_io_bridge #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  input  logic [15:0] CPU_Wdata,
  output logic [15:0] CPU_Rdata,
  output logic        Ready,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [15:0] Switches,
  output logic [15:0] HEX_Data
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam logic [19:0] IO_ADDR = 20'h0FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, ub_q, lb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   sw_s1_q, sw_s2_q;
  logic                dq_oe_q;

  logic                req, is_wr, is_io;
  logic                accept, sram_rd_done, io_rd, io_wr;
  logic                wr_nx, ub_nx, lb_nx, in_acc;
  logic                ce_n_d, ub_n_d, lb_n_d, oe_n_d, we_n_d, dq_oe_d, ready_d;

  assign req   = ~CE & (~OE | ~WE);
  assign is_wr = ~OE & ~WE;
  assign is_io = (ADDR == IO_ADDR);

  // Bus is driven only while a write occupies ACCESS
  assign SRAM_DQ = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

  // Next state, wait counter and next values of the registered SRAM strobes
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    sram_rd_done = 1'b0;
    io_rd        = 1'b0;
    io_wr        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (is_io) begin
            state_d = DONE;
            io_rd   = ~is_wr;
            io_wr   = is_wr;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d      = DONE;
          sram_rd_done = ~wr_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = req ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Attributes of the access that will be in flight next cycle
    wr_nx = accept ? is_wr : wr_q;
    ub_nx = accept ? UB    : ub_q;
    lb_nx = accept ? LB    : lb_q;
    in_acc = (state_d == ACCESS);

    ce_n_d  = ~in_acc;
    ub_n_d  = ~in_acc | ub_nx;
    lb_n_d  = ~in_acc | lb_nx;
    oe_n_d  = ~(in_acc & ~wr_nx);
    // Final ACCESS cycle (counter 0) keeps WE high to hold data past the strobe
    we_n_d  = ~(in_acc & wr_nx & (cnt_d != '0));
    dq_oe_d = in_acc & wr_nx;
    ready_d = (state_d == DONE);
  end

  // State, counter and strobe registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      dq_oe_q   <= 1'b0;
      Ready     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      SRAM_CE_N <= ce_n_d;
      SRAM_UB_N <= ub_n_d;
      SRAM_LB_N <= lb_n_d;
      SRAM_OE_N <= oe_n_d;
      SRAM_WE_N <= we_n_d;
      dq_oe_q   <= dq_oe_d;
      Ready     <= ready_d;
    end
  end

  // Request capture; SRAM address only follows SRAM requests
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q      <= 1'b0;
      ub_q      <= 1'b1;
      lb_q      <= 1'b1;
      wdata_q   <= '0;
      SRAM_ADDR <= '0;
    end else if (accept) begin
      wr_q    <= is_wr;
      ub_q    <= UB;
      lb_q    <= LB;
      wdata_q <= CPU_Wdata;
      if (!is_io) SRAM_ADDR <= ADDR;
    end
  end

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= Switches;
      sw_s2_q <= sw_s1_q;
    end
  end

  // Read data: SRAM bus at end of ACCESS, synchronised switches on I/O read
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      CPU_Rdata <= '0;
    end else if (sram_rd_done) begin
      CPU_Rdata <= SRAM_DQ;
    end else if (io_rd) begin
      CPU_Rdata <= sw_s2_q;
    end
  end

  // Hex display register with per-byte enables
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      HEX_Data <= '0;
    end else if (io_wr) begin
      if (!UB) HEX_Data[15:8] <= CPU_Wdata[15:8];
      if (!LB) HEX_Data[7:0]  <= CPU_Wdata[7:0];
    end
  end

endmodule

// File: tb/tb_sram_io_bridge.sv
// Directed bench for sram_io_bridge with a small behavioural async SRAM.
module tb_sram_io_bridge;

  logic        Clk, Reset;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  logic [15:0] CPU_Wdata, CPU_Rdata, Switches, HEX_Data;
  logic        Ready;
  logic        sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;

  int passed = 0;
  int total  = 0;

  int r_ready_tick, r_ready_cnt, r_oe, r_we, r_ce, r_ub, r_lb, r_dq_bad;
  int rdy_seen;

  sram_io_bridge #(.WAIT_STATES(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .ADDR(ADDR), .CPU_Wdata(CPU_Wdata), .CPU_Rdata(CPU_Rdata), .Ready(Ready),
    .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
    .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .Switches(Switches), .HEX_Data(HEX_Data)
  );

  // Behavioural SRAM: 256 words, reads drive the bus, writes latch per clock
  logic [15:0] mem [256];
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge Clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
    end
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One CPU access held for n cycles; optionally released as soon as Ready is seen
  task automatic run_access(input logic wr, input logic ub, input logic lb,
                            input logic [19:0] a, input logic [15:0] d,
                            input int n, input logic rel);
    r_ready_tick = 0; r_ready_cnt = 0; r_oe = 0; r_we = 0;
    r_ce = 0; r_ub = 0; r_lb = 0; r_dq_bad = 0;
    ADDR = a; CPU_Wdata = d; UB = ub; LB = lb;
    CE = 1'b0; OE = 1'b0; WE = ~wr;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (Ready) begin
        r_ready_cnt++;
        if (r_ready_tick == 0) r_ready_tick = i;
        if (rel) begin CE = 1'b1; OE = 1'b1; WE = 1'b1; end
      end
      if (!sram_ce_n) begin
        r_ce++;
        if (wr && sram_dq !== d) r_dq_bad++;
      end
      if (!sram_oe_n) r_oe++;
      if (!sram_we_n) r_we++;
      if (!sram_ub_n) r_ub++;
      if (!sram_lb_n) r_lb++;
    end
    CE = 1'b1; OE = 1'b1; WE = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b0; LB = 1'b0;
    ADDR = '0; CPU_Wdata = '0; Switches = '0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("init_ready", 32'(Ready), 32'd0);
    chk("init_ce_n", 32'(sram_ce_n), 32'd1);
    chk("init_rdata", 32'(CPU_Rdata), 32'h0);

    // Setup: full-word writes to 0x10 and 0x30
    run_access(1'b1, 1'b0, 1'b0, 20'h00010, 16'h1234, 8, 1'b1);
    chk("wr10_we_cycles", 32'(r_we), 32'd2);
    chk("wr10_ready_tick", 32'(r_ready_tick), 32'd4);
    chk("wr10_oe_cycles", 32'(r_oe), 32'd0);
    chk("wr10_mem", 32'(mem[8'h10]), 32'h1234);
    run_access(1'b1, 1'b0, 1'b0, 20'h00030, 16'h0F0F, 8, 1'b1);
    chk("wr30_mem", 32'(mem[8'h30]), 32'h0F0F);

    // SRAM read with two wait states
    run_access(1'b0, 1'b0, 1'b0, 20'h00010, 16'h0000, 8, 1'b1);
    chk("rd_oe_cycles", 32'(r_oe), 32'd3);
    chk("rd_ready_tick", 32'(r_ready_tick), 32'd4);
    chk("rd_ready_cnt", 32'(r_ready_cnt), 32'd1);
    chk("rd_we_cycles", 32'(r_we), 32'd0);
    chk("rd_data", 32'(CPU_Rdata), 32'h1234);

    // Upper-byte SRAM write
    run_access(1'b1, 1'b0, 1'b1, 20'h00020, 16'hABCD, 8, 1'b1);
    chk("ubwr_ub_cycles", 32'(r_ub), 32'd3);
    chk("ubwr_lb_cycles", 32'(r_lb), 32'd0);
    chk("ubwr_we_cycles", 32'(r_we), 32'd2);
    chk("ubwr_ce_cycles", 32'(r_ce), 32'd3);
    chk("ubwr_dq_bad", 32'(r_dq_bad), 32'd0);
    chk("ubwr_mem_hi", 32'(mem[8'h20][15:8]), 32'hAB);
    chk("ubwr_rdata_kept", 32'(CPU_Rdata), 32'h1234);

    // I/O write, lower lane only
    run_access(1'b1, 1'b1, 1'b0, 20'h0FFFF, 16'h5A5A, 3, 1'b1);
    chk("iowr_hex", 32'(HEX_Data), 32'h005A);
    chk("iowr_ready_tick", 32'(r_ready_tick), 32'd1);
    chk("iowr_sram_ce", 32'(r_ce), 32'd0);
    chk("iowr_sram_we", 32'(r_we), 32'd0);
    chk("iowr_rdata_kept", 32'(CPU_Rdata), 32'h1234);

    // I/O read of synchronised switches
    Switches = 16'hC3C3;
    tick(); tick(); tick();
    run_access(1'b0, 1'b0, 1'b0, 20'h0FFFF, 16'h0000, 3, 1'b1);
    chk("iord_data", 32'(CPU_Rdata), 32'hC3C3);
    chk("iord_ready_tick", 32'(r_ready_tick), 32'd1);
    chk("iord_sram_oe", 32'(r_oe), 32'd0);
    chk("iord_hex_kept", 32'(HEX_Data), 32'h005A);

    // Strobes held low for 10 cycles: one access only, then a fresh one
    run_access(1'b0, 1'b0, 1'b0, 20'h00030, 16'h0000, 10, 1'b0);
    chk("hold_ready_cnt", 32'(r_ready_cnt), 32'd1);
    chk("hold_oe_cycles", 32'(r_oe), 32'd3);
    chk("hold_data", 32'(CPU_Rdata), 32'h0F0F);
    run_access(1'b0, 1'b0, 1'b0, 20'h00010, 16'h0000, 8, 1'b1);
    chk("rearm_ready_cnt", 32'(r_ready_cnt), 32'd1);
    chk("rearm_data", 32'(CPU_Rdata), 32'h1234);

    // Reset during the first ACCESS cycle of a write
    ADDR = 20'h00030; CPU_Wdata = 16'h7777; UB = 1'b0; LB = 1'b0;
    CE = 1'b0; OE = 1'b0; WE = 1'b0;
    tick();
    chk("abort_we_pre", 32'(sram_we_n), 32'd0);
    #2 Reset = 1'b1;
    #1;
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_ub_lb_n", 32'({sram_ub_n, sram_lb_n}), 32'h3);
    chk("rst_ready", 32'(Ready), 32'd0);
    chk("rst_hex", 32'(HEX_Data), 32'h0000);
    chk("rst_rdata", 32'(CPU_Rdata), 32'h0000);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    CE = 1'b1; OE = 1'b1; WE = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Ready) rdy_seen++;
    end
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Ready) rdy_seen++;
    end
    chk("abort_no_ready", 32'(rdy_seen), 32'd0);
    run_access(1'b0, 1'b0, 1'b0, 20'h00030, 16'h0000, 8, 1'b1);
    chk("post_rst_ready_tick", 32'(r_ready_tick), 32'd4);
    chk("post_rst_data", 32'(CPU_Rdata), 32'h0F0F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
